clk_event_monitor: RTL and testbench
====================================

// Module: clk_event_monitor
// PURPOSE
//   Multi-channel, windowed edge counter for clock/strobe health monitoring (MDC, GMII Tx/Rx, etc.).
//   Asynchronous monitored signals are synchronised into ACLK.
//   Rising edges are counted per channel over a programmable window of ACLK cycles.
//   Results are latched at window end for processor readout, in one-shot or continuous mode.
// PARAMETERS
//   NUM_CH  4   number of monitored inputs (1..16)
//   CNT_W   32  width of each per-channel edge counter/result
//   WIN_W   32  width of the window-length timer
// PORTS
//   ACLK      in   1             system clock; all logic in this domain
//   ARESET    in   1             asynchronous, active-high reset
//   sig_in    in   NUM_CH        monitored signals, asynchronous to ACLK
//   ch_en     in   NUM_CH        per-channel count enable (level)
//   ch_clr    in   NUM_CH        per-channel clear (level, synchronous)
//   win_len   in   WIN_W         window length in ACLK cycles; sampled on accepted start
//   cont      in   1             1 = continuous back-to-back windows
//   start     in   1             start request (pulse); accepted only in IDLE
//   abort     in   1             stop the current window (pulse)
//   busy      out  1             1 in COUNT/LATCH
//   done      out  1             1-cycle pulse when results are latched
//   win_cnt   out  16            completed-window count, wraps
//   cnt_out   out  NUM_CH*CNT_W  latched results; ch i at [i*CNT_W +: CNT_W]
//   ovf       out  NUM_CH        per-channel sticky overflow
// BEHAVIOUR
//   - Reset: all outputs, live counters, timer and synchronisers = 0; state = IDLE.
//   - Input path: 2-FF synchroniser, then edge register.
//     - rise[i] = s2 & ~s3; first pulse 3 ACLK edges after a sig_in rise.
//     - Pulses narrower than 1 ACLK period may be missed; this is not an error.
//   - State machine: IDLE, COUNT, LATCH.
//     - IDLE: on start, clear the live counters, load timer = win_len, go to COUNT.
//       - If win_len == 0, go directly to LATCH; results are all 0.
//     - COUNT: live[i] += 1 when rise[i] & ch_en[i]. Timer decrements each cycle.
//       - When timer == 1, next state is LATCH, so exactly win_len cycles are counted.
//     - LATCH (1 cycle):
//       - cnt_out <= live; done = 1; win_cnt += 1.
//       - If cont = 1: reload timer = win_len (win_len resampled), clear live, go to COUNT.
//         A rise on this cycle counts as 1 in the new window.
//       - Else go to IDLE.
//   - start while busy: ignored.
//   - abort in COUNT: go to IDLE, clear live; cnt_out, win_cnt and done are unchanged.
//   - abort coincident with LATCH: the latch completes, then go to IDLE regardless of cont.
//   - ch_clr[i]: clears live[i], cnt_out slice i and ovf[i] that cycle.
//     Takes priority over increment and over LATCH for that channel.
//   - ch_en[i] = 0: live[i] holds its value; the timer still runs.
//   - Overflow: when live[i] is all-ones and a counted rise occurs, ovf[i] <= 1.
//     ovf[i] stays set until ch_clr[i] or reset.
// CONFIGURATION
//   CLK_EVENT_MONITOR_SATURATE_EN
//     defined: live[i] saturates at {CNT_W{1'b1}}; ovf[i] is set as above.
//     undefined: live[i] wraps to 0; ovf[i] is still set.
//   The only difference is the counter value after the terminal count.
// TESTING
//   1. Reset during COUNT with live = 5.
//      -> All outputs 0 in the same cycle; IDLE; busy = 0.
//   2. NUM_CH = 4; win_len = 100; sig_in[0] = ACLK/4 square wave; ch_en = 4'b0001; start.
//      -> done 101 cycles after start; cnt_out[0] = 25 +/-1; other channels 0; win_cnt = 1.
//   3. cont = 1, win_len = 10, steady input on ch1.
//      -> done every 11 cycles; no edge lost or double-counted across windows; win_cnt increments.
//   4. win_len = 0, start.
//      -> done on the next cycle; cnt_out = 0; return to IDLE.
//   5. CNT_W = 4, win_len = 40, ACLK/2 input on ch0.
//      -> ovf[0] = 1; cnt_out[0] = 4'hF with the SATURATE_EN macro defined, wrapped value without it.
//   6. abort at cycle 5 of a 20-cycle window; then start during busy; then ch_clr[0] during LATCH.
//      -> After abort: no done, previous cnt_out kept.
//      -> Start during busy: ignored.
//      -> ch_clr during LATCH: cnt_out[0] = 0.

Source files
------------

// File: rtl/clk_event_monitor.sv
// Multi-channel windowed rising-edge counter for clock/strobe health monitoring.
// Optional feature macro: CLK_EVENT_MONITOR_SATURATE_EN (live counters saturate instead of wrapping).
module clk_event_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_clr,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    cont,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             win_cnt,
  output logic [NUM_CH*CNT_W-1:0] cnt_out,
  output logic [NUM_CH-1:0]       ovf
);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_LATCH} state_t;

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                  state_q, state_d;
  logic [WIN_W-1:0]        timer_q, timer_d;
  logic [NUM_CH-1:0]       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NUM_CH-1:0]       rise;
  logic [CNT_W-1:0]        live_q [NUM_CH];
  logic [CNT_W-1:0]        live_d [NUM_CH];
  logic [CNT_W-1:0]        base   [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic [15:0]             win_cnt_q, win_cnt_d;
  logic                    clr_live, count_en, latch_now;

  // Two synchroniser stages, then one more stage for edge detection.
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    win_cnt_d = win_cnt_q;
    clr_live  = 1'b0;
    count_en  = 1'b0;
    latch_now = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr_live = 1'b1;
          timer_d  = win_len;
          state_d  = (win_len == '0) ? ST_LATCH : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          clr_live = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          count_en = 1'b1;
          timer_d  = timer_q - WIN_ONE;
          if (timer_q <= WIN_ONE) state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        latch_now = 1'b1;
        win_cnt_d = win_cnt_q + 16'd1;
        // Back-to-back windows: a rise in this cycle belongs to the new window.
        if (cont && !abort) begin
          clr_live = 1'b1;
          count_en = 1'b1;
          timer_d  = win_len;
          state_d  = (win_len == '0) ? ST_LATCH : ST_COUNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_d = latch_now;

  always_comb begin
    cnt_out_d = cnt_out_q;
    ovf_d     = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      base[i]   = clr_live ? '0 : live_q[i];
      live_d[i] = base[i];
      if (count_en && rise[i] && ch_en[i]) begin
        if (base[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
`ifdef CLK_EVENT_MONITOR_SATURATE_EN
          live_d[i] = CNT_MAX;
`else
          live_d[i] = '0;
`endif
        end else begin
          live_d[i] = base[i] + CNT_ONE;
        end
      end
      if (latch_now) cnt_out_d[i*CNT_W +: CNT_W] = live_q[i];
      // Channel clear overrides both counting and the latch.
      if (ch_clr[i]) begin
        live_d[i]                    = '0;
        cnt_out_d[i*CNT_W +: CNT_W]  = '0;
        ovf_d[i]                     = 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      cnt_out_q <= '0;
      ovf_q     <= '0;
      done_q    <= 1'b0;
      win_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) live_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      cnt_out_q <= cnt_out_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      win_cnt_q <= win_cnt_d;
      for (int i = 0; i < NUM_CH; i++) live_q[i] <= live_d[i];
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign win_cnt = win_cnt_q;
  assign cnt_out = cnt_out_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_clk_event_monitor.sv
// Scoreboard bench for clk_event_monitor: a 32-bit-counter instance plus a 4-bit one for overflow.
// Expected window results are computed from the bench's own waveform description when each window starts.
module tb_clk_event_monitor;

  localparam int NCH = 4;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [3:0]   sig_in, ch_en, ch_clr;
  logic [31:0]  win_len;
  logic         cont, start, abort;
  logic         busy, done;
  logic [15:0]  win_cnt;
  logic [127:0] cnt_out;
  logic [3:0]   ovf;
  logic         busy4, done4;
  logic [15:0]  win_cnt4;
  logic [15:0]  cnt_out4;
  logic [3:0]   ovf4;

  typedef struct {
    string        tag;
    int           done_edge;
    logic [127:0] cnt;
    logic [15:0]  wcnt;
    bit           chk4;
    logic [15:0]  cnt4;
    logic [3:0]   ovf4;
  } exp_t;

  exp_t         sb[$];
  exp_t         mx;
  int           vectors = 0;
  int           miscompares = 0;
  int           edge_n = 0;
  int           exp_win = 0;
  int           wave_period [NCH];
  int           wave_t0 [NCH];
  logic [127:0] last_cnt;

  clk_event_monitor #(.NUM_CH(4), .CNT_W(32), .WIN_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .sig_in(sig_in), .ch_en(ch_en), .ch_clr(ch_clr),
    .win_len(win_len), .cont(cont), .start(start), .abort(abort),
    .busy(busy), .done(done), .win_cnt(win_cnt), .cnt_out(cnt_out), .ovf(ovf)
  );

  clk_event_monitor #(.NUM_CH(4), .CNT_W(4), .WIN_W(32)) dut4 (
    .ACLK(ACLK), .ARESET(ARESET), .sig_in(sig_in), .ch_en(ch_en), .ch_clr(ch_clr),
    .win_len(win_len), .cont(cont), .start(start), .abort(abort),
    .busy(busy4), .done(done4), .win_cnt(win_cnt4), .cnt_out(cnt_out4), .ovf(ovf4)
  );

  always #5 ACLK = ~ACLK;

  // Posedge index: inputs driven now are sampled at edge_n+1.
  always @(posedge ACLK) edge_n <= edge_n + 1;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Value of sig_in[ch] as sampled at posedge e.
  function automatic bit waveVal(input int ch, input int e);
    if (wave_period[ch] == 0 || e < wave_t0[ch]) return 1'b0;
    return ((e - wave_t0[ch]) % wave_period[ch]) < (wave_period[ch] / 2);
  endfunction

  // A rise first sampled at edge c is counted at edge c+2.
  function automatic int countRises(input int ch, input int lo, input int hi);
    int n = 0;
    for (int e = lo; e <= hi; e++)
      if (waveVal(ch, e - 2) && !waveVal(ch, e - 3)) n++;
    return n;
  endfunction

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge ACLK);
      for (int c = 0; c < NCH; c++) sig_in[c] = waveVal(c, edge_n + 1);
    end
  endtask

  task automatic setWave(input int ch, input int period);
    wave_period[ch] = period;
    wave_t0[ch]     = edge_n + 2;
  endtask

  task automatic kickStart(input int wl, output int s);
    win_len = wl;
    start   = 1'b1;
    s       = edge_n + 1;
    applyStimulus(1);
    start   = 1'b0;
  endtask

  task automatic pushWindow(input string tag, input int lo, input int hi, input int de,
                            input logic [3:0] zero_mask, input bit chk4);
    exp_t x;
    int   n0;
    logic [3:0] v4;
    x.tag       = tag;
    x.done_edge = de;
    x.cnt       = '0;
    for (int c = 0; c < NCH; c++)
      if (ch_en[c] && !zero_mask[c]) x.cnt[c*32 +: 32] = countRises(c, lo, hi);
    exp_win++;
    x.wcnt = 16'(exp_win);
    n0 = int'(x.cnt[31:0]);
`ifdef CLK_EVENT_MONITOR_SATURATE_EN
    v4 = (n0 > 15) ? 4'hF : n0[3:0];
`else
    v4 = n0[3:0];
`endif
    x.chk4   = chk4;
    x.cnt4   = {12'h000, v4};
    x.ovf4   = (n0 > 15) ? 4'b0001 : 4'b0000;
    last_cnt = x.cnt;
    sb.push_back(x);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      applyStimulus(1);
      k++;
    end
    if (sb.size() != 0) begin
      checkOutput({tag, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending window.
  always @(negedge ACLK) begin
    if (!ARESET && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1'b1, 1'b0);
      end else begin
        mx = sb.pop_front();
        checkOutput({mx.tag, "_edge"}, edge_n, mx.done_edge);
        checkOutput({mx.tag, "_cnt"}, cnt_out, mx.cnt);
        checkOutput({mx.tag, "_wcnt"}, win_cnt, mx.wcnt);
        checkOutput({mx.tag, "_ovf"}, ovf, 4'b0000);
        if (mx.chk4) begin
          checkOutput({mx.tag, "_done4"}, done4, 1'b1);
          checkOutput({mx.tag, "_wcnt4"}, win_cnt4, mx.wcnt);
          checkOutput({mx.tag, "_cnt4"}, cnt_out4, mx.cnt4);
          checkOutput({mx.tag, "_ovf4"}, ovf4, mx.ovf4);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, l;
    logic [127:0] keep_cnt;
    ARESET = 1'b1; sig_in = '0; ch_en = '0; ch_clr = '0; win_len = '0;
    cont = 1'b0; start = 1'b0; abort = 1'b0; last_cnt = '0;
    for (int c = 0; c < NCH; c++) begin wave_period[c] = 0; wave_t0[c] = 0; end
    repeat (3) @(negedge ACLK);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wcnt", win_cnt, 0);
    checkOutput("rst_cnt", cnt_out, 0);
    checkOutput("rst_ovf", ovf, 0);
    ARESET = 1'b0;
    applyStimulus(2);

    // Single window of 100 cycles, ACLK/4 on ch0; a start mid-window must be ignored.
    ch_en = 4'b0001; setWave(0, 4); setWave(1, 0); applyStimulus(4);
    kickStart(100, s);
    pushWindow("t2", s + 1, s + 100, s + 101, 4'b0000, 1'b0);
    applyStimulus(10);
    checkOutput("t2_busy", busy, 1);
    start = 1'b1; applyStimulus(1); start = 1'b0;
    waitDrain("t2", 130);
    applyStimulus(1);
    checkOutput("t2_idle", busy, 0);

    // Continuous 10-cycle windows on ch1; the LATCH cycle feeds the next window.
    ch_en = 4'b0010; setWave(0, 0); setWave(1, 4); applyStimulus(4);
    cont = 1'b1;
    kickStart(10, s);
    pushWindow("t3w0", s + 1, s + 10, s + 11, 4'b0000, 1'b0);
    l = s + 11;
    for (int k = 1; k < 4; k++) begin
      pushWindow($sformatf("t3w%0d", k), l, l + 10, l + 11, 4'b0000, 1'b0);
      l += 11;
    end
    while (edge_n < s + 38) applyStimulus(1);
    cont = 1'b0;
    waitDrain("t3", 60);
    applyStimulus(1);
    checkOutput("t3_idle", busy, 0);

    // Zero-length window.
    kickStart(0, s);
    pushWindow("t4", s + 1, s, s + 1, 4'b0000, 1'b0);
    waitDrain("t4", 10);
    applyStimulus(1);
    checkOutput("t4_idle", busy, 0);

    // Clear everything, then overflow the 4-bit instance with ACLK/2 on ch0.
    ch_clr = 4'hF; applyStimulus(1); ch_clr = 4'h0;
    checkOutput("t5_clr_cnt", cnt_out, 0);
    checkOutput("t5_clr_ovf", ovf, 0);
    checkOutput("t5_clr_ovf4", ovf4, 0);
    ch_en = 4'b0001; setWave(0, 2); setWave(1, 0); applyStimulus(4);
    kickStart(40, s);
    pushWindow("t5", s + 1, s + 40, s + 41, 4'b0000, 1'b1);
    waitDrain("t5", 60);
    applyStimulus(1);
    checkOutput("t5_busy4", busy4, 0);
    keep_cnt = last_cnt;

    // Abort in cycle 5: no done, previous results kept.
    ch_en = 4'b0011; setWave(0, 2); setWave(1, 4); applyStimulus(4);
    kickStart(20, s);
    while (edge_n < s + 4) applyStimulus(1);
    abort = 1'b1; applyStimulus(1); abort = 1'b0;
    applyStimulus(25);
    checkOutput("t6_abort_busy", busy, 0);
    checkOutput("t6_abort_cnt", cnt_out, keep_cnt);
    checkOutput("t6_abort_wcnt", win_cnt, 16'(exp_win));

    // Ignored start while busy, then ch_clr[0] on the LATCH cycle.
    kickStart(20, s);
    pushWindow("t6", s + 1, s + 20, s + 21, 4'b0001, 1'b0);
    while (edge_n < s + 2) applyStimulus(1);
    start = 1'b1; win_len = 5; applyStimulus(1); start = 1'b0;
    while (edge_n < s + 20) applyStimulus(1);
    ch_clr = 4'b0001; applyStimulus(1); ch_clr = 4'b0000;
    waitDrain("t6", 20);

    // Abort on the LATCH cycle with cont set: latch completes, then idle.
    cont = 1'b1;
    kickStart(8, s);
    pushWindow("t6b", s + 1, s + 8, s + 9, 4'b0000, 1'b0);
    while (edge_n < s + 8) applyStimulus(1);
    abort = 1'b1; applyStimulus(1); abort = 1'b0;
    applyStimulus(20);
    waitDrain("t6b", 5);
    checkOutput("t6b_idle", busy, 0);
    cont = 1'b0;

    // Asynchronous reset in the middle of a counting window.
    ch_en = 4'b0001; setWave(0, 2); applyStimulus(4);
    kickStart(50, s);
    applyStimulus(12);
    checkOutput("t1_busy_pre", busy, 1);
    #2 ARESET = 1'b1;
    #1;
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_done", done, 0);
    checkOutput("t1_wcnt", win_cnt, 0);
    checkOutput("t1_cnt", cnt_out, 0);
    checkOutput("t1_ovf", ovf, 0);
    applyStimulus(2);
    ARESET = 1'b0;
    sb.delete();
    exp_win = 0;
    applyStimulus(2);

    // Window count restarts from 1 after reset.
    kickStart(0, s);
    pushWindow("post_rst", s + 1, s, s + 1, 4'b0000, 1'b0);
    waitDrain("post_rst", 10);

    applyStimulus(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
